pkt_rcv: RTL and testbench



---
 rtl/pkt_pkg.sv | 34 +++
 rtl/pkt_rcv_if.sv | 42 ++++
 rtl/spi_in_sync.sv | 40 ++++
 rtl/pkt_rcv.sv | 176 +++++++++++++++++
 tb/tb_pkt_rcv.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pkt_pkg.sv
// Shared packet definitions for the command-packet link (sender and receiver).
// Keeps the 16-bit packet split into address and data bytes aligned on both ends.
package pkt_pkg;

    localparam int PKT_W  = 16;
    localparam int ADDR_W = 8;
    localparam int DAT_W  = 8;
    // The counter must be able to hold the value PKT_W itself.
    localparam int CNT_W  = 5;

    // Receiver frame states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2,
        WAIT = 2'd3
    } pkt_state_e;

    // Shift one serial bit into the packet register.
    // MSB-first: the first bit ends up in bit PKT_W-1.
    // LSB-first: the first bit ends up in bit 0.
    function automatic logic [PKT_W-1:0] shift_in(input logic [PKT_W-1:0] sr,
                                                   input logic             b,
                                                   input logic             msb_first);
        logic [PKT_W-1:0] r;
        if (msb_first) begin
            r = {sr[PKT_W-2:0], b};
        end else begin
            r = {b, sr[PKT_W-1:1]};
        end
        return r;
    endfunction

endpackage

// File: rtl/pkt_rcv_if.sv
// Serial link plus parallel result bus of the packet receiver.
// The master modport is the side that drives the SPI lines (sender or bench);
// the slave modport is the receiver.
// Optional macro: PKT_RCV_ECHO_EN adds the sdo echo line.
//
// Handshake: vld is a single-cycle strobe; addr/dat are valid in the cycle vld
// is high and stay unchanged until the next vld (or reset). There is no ready:
// the consumer must take the word in the vld cycle. abrt is a single-cycle
// strobe reporting a truncated frame; addr/dat are not touched by it.
interface pkt_rcv_if;
    import pkt_pkg::*;

    logic              sclk;
    logic              ss;
    logic              sdi;
    logic [ADDR_W-1:0] addr;
    logic [DAT_W-1:0]  dat;
    logic              vld;
    logic              abrt;
    logic              busy;
    pkt_state_e        state;   // debug view of the receiver FSM
`ifdef PKT_RCV_ECHO_EN
    logic              sdo;
`endif

    modport master (
        output sclk, ss, sdi,
        input  addr, dat, vld, abrt, busy, state
`ifdef PKT_RCV_ECHO_EN
        , input sdo
`endif
    );

    modport slave (
        input  sclk, ss, sdi,
        output addr, dat, vld, abrt, busy, state
`ifdef PKT_RCV_ECHO_EN
        , output sdo
`endif
    );

endinterface

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous input line, followed by a
// history flop that yields single-cycle rise/fall pulses in the clk domain.
// STAGES is meant to be 2 or 3. All flops reset to RST_VAL, the idle level
// of the line, so leaving reset never produces a spurious edge.
module spi_in_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              hist_q;
    logic              hist_d;

    assign sync_d = {sync_q[STAGES-2:0], d_i};
    assign hist_d = sync_q[STAGES-1];

    // Synchronizer chain and edge-history register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign lvl_o  = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/pkt_rcv.sv
// SPI mode-0 slave receiver for the 16-bit command packet (address byte, then
// data byte). sclk/ss/sdi are oversampled in the clk domain; each complete
// packet is presented as addr/dat with a one-cycle vld, a frame cut short by
// ss release gives a one-cycle abrt.
// Optional macro: PKT_RCV_ECHO_EN adds sdo, which echoes every received bit
// one sclk period later for link checking.
module pkt_rcv
    import pkt_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input logic     clk,
    input logic     rst_n,
    pkt_rcv_if.slave bus
);

    logic sclk_lvl_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic ss_lvl;
    logic ss_rise;
    logic ss_fall;
    logic sdi_lvl;
    logic sdi_rise_unused;
    logic sdi_fall_unused;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (bus.sclk),
        .lvl_o  (sclk_lvl_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (bus.ss),
        .lvl_o  (ss_lvl),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    // sdi goes through the same number of stages as sclk, so the level seen
    // alongside a detected sclk rise is the bit the master set up before it.
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (bus.sdi),
        .lvl_o  (sdi_lvl),
        .rise_o (sdi_rise_unused),
        .fall_o (sdi_fall_unused)
    );

    pkt_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [PKT_W-1:0]  shift_q, shift_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DAT_W-1:0]  dat_q,   dat_d;
    logic              abrt_q,  abrt_d;

    // Frame state, bit counter, shift register and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            dat_q   <= '0;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            abrt_q  <= abrt_d;
        end
    end

    // Next-state logic. A bit arriving in the same cycle as ss rise is still
    // taken, so the 16th bit wins over a simultaneous release. addr/dat load
    // on the edge that enters DONE, making them valid exactly while vld is high.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        dat_d   = dat_q;
        abrt_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            RECV: begin
                if (sclk_rise) begin
                    shift_d = shift_in(shift_q, sdi_lvl, MSB_FIRST);
                    cnt_d   = cnt_q + 1'b1;
                end
                if (cnt_d == CNT_W'(PKT_W)) begin
                    state_d = DONE;
                    addr_d  = shift_d[PKT_W-1 -: ADDR_W];
                    dat_d   = shift_d[DAT_W-1:0];
                end else if (ss_rise) begin
                    state_d = IDLE;
                    abrt_d  = (cnt_d != '0);
                end
            end
            DONE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Level rather than edge: the release may already have been
                // seen together with the last bit while still in RECV.
                if (ss_lvl) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.addr  = addr_q;
    assign bus.dat   = dat_q;
    assign bus.vld   = (state_q == DONE);
    assign bus.abrt  = abrt_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.state = state_q;

`ifdef PKT_RCV_ECHO_EN
    logic echo_bit_q, echo_bit_d;
    logic sdo_q,      sdo_d;

    always_comb begin
        echo_bit_d = echo_bit_q;
        sdo_d      = sdo_q;
        if (state_q == IDLE) begin
            echo_bit_d = 1'b0;
            sdo_d      = 1'b0;
        end else begin
            if ((state_q == RECV) && sclk_rise) begin
                echo_bit_d = sdi_lvl;
            end
            if (sclk_fall) begin
                sdo_d = echo_bit_q;
            end
        end
    end

    // Echo path: capture on sclk rise, present on the following sclk fall so
    // the master reads bit k at rise k+1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            echo_bit_q <= 1'b0;
            sdo_q      <= 1'b0;
        end else begin
            echo_bit_q <= echo_bit_d;
            sdo_q      <= sdo_d;
        end
    end

    assign bus.sdo = sdo_q & (state_q != IDLE);
`else
    logic echo_unused;
    assign echo_unused = sclk_fall;
`endif

endmodule

// File: tb/tb_pkt_rcv.sv
// Bench for pkt_rcv: directed and random SPI frames, each checked against a
// frame-level model (bits sent per select -> vld/abrt/held fields).
module tb_pkt_rcv;
    import pkt_pkg::*;

    localparam int SYNC = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pkt_rcv_if bus();

    pkt_rcv #(.SYNC_STAGES(SYNC), .MSB_FIRST(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- output monitor ----------------
    int         vld_cnt   = 0;
    int         abrt_cnt  = 0;
    int         wide_cnt  = 0;
    int         vld_cyc   = 0;
    logic [7:0] cap_addr  = 8'h00;
    logic [7:0] cap_dat   = 8'h00;
    logic       vld_prev  = 1'b0;
    logic       abrt_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.vld === 1'b1) begin
            vld_cnt  <= vld_cnt + 1;
            vld_cyc  <= cyc;
            cap_addr <= bus.addr;
            cap_dat  <= bus.dat;
        end
        if (bus.abrt === 1'b1) abrt_cnt <= abrt_cnt + 1;
        if ((bus.vld === 1'b1 && vld_prev) || (bus.abrt === 1'b1 && abrt_prev))
            wide_cnt <= wide_cnt + 1;
        vld_prev  <= (bus.vld === 1'b1);
        abrt_prev <= (bus.abrt === 1'b1);
    end

    // ---------------- scoreboard / model ----------------
    logic [15:0] exp_q[$];
    logic [7:0]  m_addr = 8'h00;
    logic [7:0]  m_dat  = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transmission order: element i of the result is the i-th bit on the wire.
    function automatic logic [31:0] make_stream(input logic [15:0] w, input logic [31:0] extra);
        logic [31:0] s;
        s = extra;
        for (int i = 0; i < 16; i++) s[i] = w[15-i];
        return s;
    endfunction

    // ---------------- driver ----------------
    task automatic send_frame(input logic [31:0] s, input int nbits, input int half,
                              input bit simul, input int rst_at, output int rise16_cyc);
        rise16_cyc = -1;
        @(negedge clk);
        bus.ss = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_in_frame", {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            bus.sdi = s[i];
            repeat (half) @(negedge clk);
`ifdef PKT_RCV_ECHO_EN
            if (half >= 4 && i >= 1 && i < 16)
                check("sdo_echo", {31'd0, bus.sdo}, {31'd0, s[i-1]});
`endif
            bus.sclk = 1'b1;
            if (i == 15) rise16_cyc = cyc;
            if (simul && i == nbits - 1) bus.ss = 1'b1;
            repeat (half) @(negedge clk);
            bus.sclk = 1'b0;
            if (i == rst_at) begin
                rst_n  = 1'b0;
                bus.ss = 1'b1;
                repeat (3) @(negedge clk);
                check("rst_mid_addr", {24'd0, bus.addr}, 32'h0);
                check("rst_mid_dat",  {24'd0, bus.dat},  32'h0);
                check("rst_mid_busy", {31'd0, bus.busy}, 32'h0);
                rst_n = 1'b1;
                repeat (6) @(negedge clk);
                return;
            end
        end
        repeat (half) @(negedge clk);
        bus.ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // One frame through the model and the DUT, then compare.
    task automatic run_frame(input logic [15:0] w, input logic [31:0] extra, input int nbits,
                             input int half, input bit simul);
        int v0, a0, r16;
        logic [15:0] e;
        v0 = vld_cnt;
        a0 = abrt_cnt;
        send_frame(make_stream(w, extra), nbits, half, simul, -1, r16);
        @(negedge clk);
        if (nbits >= 16) begin
            exp_q.push_back(w);
            m_addr = w[15:8];
            m_dat  = w[7:0];
        end
        check("vld_count",  vld_cnt - v0,  (nbits >= 16) ? 32'd1 : 32'd0);
        check("abrt_count", abrt_cnt - a0, (nbits >= 1 && nbits <= 15) ? 32'd1 : 32'd0);
        if (nbits >= 16) begin
            e = exp_q.pop_front();
            check("vld_addr",    {24'd0, cap_addr}, {24'd0, e[15:8]});
            check("vld_dat",     {24'd0, cap_dat},  {24'd0, e[7:0]});
            check("vld_latency", vld_cyc - r16, SYNC + 1);
        end
        check("addr_held", {24'd0, bus.addr}, {24'd0, m_addr});
        check("dat_held",  {24'd0, bus.dat},  {24'd0, m_dat});
        check("busy_after", {31'd0, bus.busy}, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL timeout: stimulus did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int v0, a0, r16;
        logic [15:0] w;
        bus.sclk = 1'b0;
        bus.ss   = 1'b1;
        bus.sdi  = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr", {24'd0, bus.addr}, 32'h0);
        check("rst_dat",  {24'd0, bus.dat},  32'h0);
        check("rst_vld",  {31'd0, bus.vld},  32'h0);
        check("rst_abrt", {31'd0, bus.abrt}, 32'h0);
        check("rst_busy", {31'd0, bus.busy}, 32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_vld",  vld_cnt,  32'd0);
        check("idle_abrt", abrt_cnt, 32'd0);
        check("idle_busy", {31'd0, bus.busy}, 32'h0);

        // Basic frame at clk/8.
        run_frame(16'hA53C, 32'h0, 16, 4, 1'b0);
        // Truncated after 9 bits: abrt, fields hold.
        run_frame(16'($urandom), $urandom, 9, 4, 1'b0);
        run_frame(16'h01FF, 32'h0, 16, 4, 1'b0);
        // 20 clocks under one select: only the first 16 count.
        run_frame(16'($urandom), $urandom, 20, 3, 1'b0);

        // Reset after 10 bits: fields cleared, no strobes.
        v0 = vld_cnt;
        a0 = abrt_cnt;
        send_frame(make_stream(16'h1357, 32'h0), 16, 4, 1'b0, 9, r16);
        m_addr = 8'h00;
        m_dat  = 8'h00;
        check("rst_frame_vld",  vld_cnt - v0,  32'd0);
        check("rst_frame_abrt", abrt_cnt - a0, 32'd0);
        check("rst_frame_addr", {24'd0, bus.addr}, 32'h0);
        run_frame(16'h7E81, 32'h0, 16, 4, 1'b0);

        // 16th rise and ss release together: packet completes.
        run_frame(16'($urandom), 32'h0, 16, 4, 1'b1);
        // Empty select: no strobes at all.
        run_frame(16'($urandom), 32'h0, 0, 4, 1'b0);
        // Fastest legal sclk.
        run_frame(16'($urandom), $urandom, 16, 2, 1'b0);
`ifdef PKT_RCV_ECHO_EN
        run_frame(16'hC35A, 32'h0, 16, 4, 1'b0);
`endif

        for (int k = 0; k < 10; k++) begin
            w = 16'($urandom);
            run_frame(w, $urandom, $urandom_range(0, 20), $urandom_range(2, 5), 1'b0);
        end

        check("pulse_width", wide_cnt, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
